pd_rx_ctrl: RTL and testbench

- Receive-path controller that sits directly behind the BMC decoder (`bmc_decoder`) in the USB PD PHY.
- Gates the decoder's enable and consumes its per-bit strobe (rdy/bmc_q/ps).
- Sequences a received frame: preamble qualification → SOP* ordered-set search → 4b5b symbol decode → byte assembly → EOP.
- Hands bytes to the CRC/protocol layer and reports frame type, completion and errors.

---
 rtl/pd_pkg.sv | 74 +++++++
 rtl/pd_rx_ctrl_if.sv | 31 +++
 rtl/pd_4b5b_dec.sv | 50 +++++
 rtl/pd_rx_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pd_rx_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pd_pkg.sv
// pd_pkg: shared USB PD receive-path definitions.
//   - 4b5b data (D0..DF) and K-code (SYNC1..3, RST1..2, EOP) symbol values
//   - ordered-set tuples packed {f3,f2,f1,f0}, where f0 is the first symbol received
//   - sop_type / err_code / FSM state encodings
//   - os_match(): 3-of-4 ordered-set field comparison
// Symbol bit0 is the first bit on the wire.
package pd_pkg;

    localparam logic [4:0] D0 = 5'b11110;
    localparam logic [4:0] D1 = 5'b01001;
    localparam logic [4:0] D2 = 5'b10100;
    localparam logic [4:0] D3 = 5'b10101;
    localparam logic [4:0] D4 = 5'b01010;
    localparam logic [4:0] D5 = 5'b01011;
    localparam logic [4:0] D6 = 5'b01110;
    localparam logic [4:0] D7 = 5'b01111;
    localparam logic [4:0] D8 = 5'b10010;
    localparam logic [4:0] D9 = 5'b10011;
    localparam logic [4:0] DA = 5'b10110;
    localparam logic [4:0] DB = 5'b10111;
    localparam logic [4:0] DC = 5'b11010;
    localparam logic [4:0] DD = 5'b11011;
    localparam logic [4:0] DE = 5'b11100;
    localparam logic [4:0] DF = 5'b11101;

    localparam logic [4:0] SYNC1 = 5'b11000;
    localparam logic [4:0] SYNC2 = 5'b10001;
    localparam logic [4:0] SYNC3 = 5'b00110;
    localparam logic [4:0] RST1  = 5'b00111;
    localparam logic [4:0] RST2  = 5'b11001;
    localparam logic [4:0] EOP   = 5'b01101;

    // Ordered sets; the lowest field is the first symbol received.
    localparam logic [19:0] OS_SOP   = {SYNC2, SYNC1, SYNC1, SYNC1};
    localparam logic [19:0] OS_SOP1  = {SYNC3, SYNC3, SYNC1, SYNC1};
    localparam logic [19:0] OS_SOP2  = {SYNC3, SYNC1, SYNC3, SYNC1};
    localparam logic [19:0] OS_HARD  = {RST2,  RST1,  RST1,  RST1};
    localparam logic [19:0] OS_CABLE = {SYNC3, RST1,  SYNC1, RST1};

    typedef enum logic [2:0] {
        SOPT_SOP   = 3'd0,
        SOPT_SOP1  = 3'd1,
        SOPT_SOP2  = 3'd2,
        SOPT_HARD  = 3'd3,
        SOPT_CABLE = 3'd4
    } sop_type_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SYM     = 3'd1,
        ERR_TIMEOUT = 3'd2,
        ERR_OVF     = 3'd3,
        ERR_ODD     = 3'd4,
        ERR_CARRIER = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_SOPSRCH = 3'd2,
        ST_DATA    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // An ordered set is recognised when at least 3 of its 4 symbols match.
    function automatic logic os_match(input logic [19:0] w, input logic [19:0] os);
        logic [2:0] hits;
        hits = 3'd0;
        for (int i = 0; i < 4; i++)
            if (w[i*5 +: 5] == os[i*5 +: 5]) hits = hits + 3'd1;
        return hits >= 3'd3;
    endfunction

endpackage

// File: rtl/pd_rx_ctrl_if.sv
// pd_rx_ctrl_if: bundles the decoder strobe inputs and the frame/byte outputs
// of the receive controller.
//   master: the controller (drives dec_enable, sop_*, byte_*, pkt_*, err_code, busy)
//   slave : the surrounding logic (drives rx_en, bit_rdy, bit_q, pkt_active)
interface pd_rx_ctrl_if;
    logic       rx_en;
    logic       dec_enable;
    logic       bit_rdy;
    logic       bit_q;
    logic       pkt_active;
    logic       sop_valid;
    logic [2:0] sop_type;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       pkt_done;
    logic       pkt_err;
    logic [2:0] err_code;
    logic       busy;

    modport master (
        input  rx_en, bit_rdy, bit_q, pkt_active,
        output dec_enable, sop_valid, sop_type, byte_valid, byte_data,
               pkt_done, pkt_err, err_code, busy
    );

    modport slave (
        output rx_en, bit_rdy, bit_q, pkt_active,
        input  dec_enable, sop_valid, sop_type, byte_valid, byte_data,
               pkt_done, pkt_err, err_code, busy
    );
endinterface

// File: rtl/pd_4b5b_dec.sv
// pd_4b5b_dec: combinational 4b5b symbol decoder.
//   sym      in  5  received symbol, bit0 first on the wire
//   nibble   out 4  decoded value (0 when not a data symbol)
//   is_data  out 1  sym is one of D0..DF
//   is_eop   out 1  sym is EOP
//   is_kcode out 1  sym is any K-code (SYNC1..3, RST1..2, EOP)
module pd_4b5b_dec
    import pd_pkg::*;
(
    input  logic [4:0] sym,
    output logic [3:0] nibble,
    output logic       is_data,
    output logic       is_eop,
    output logic       is_kcode
);
    always_comb begin
        nibble   = 4'h0;
        is_data  = 1'b1;
        is_eop   = 1'b0;
        is_kcode = 1'b0;
        case (sym)
            D0: nibble = 4'h0;
            D1: nibble = 4'h1;
            D2: nibble = 4'h2;
            D3: nibble = 4'h3;
            D4: nibble = 4'h4;
            D5: nibble = 4'h5;
            D6: nibble = 4'h6;
            D7: nibble = 4'h7;
            D8: nibble = 4'h8;
            D9: nibble = 4'h9;
            DA: nibble = 4'hA;
            DB: nibble = 4'hB;
            DC: nibble = 4'hC;
            DD: nibble = 4'hD;
            DE: nibble = 4'hE;
            DF: nibble = 4'hF;
            SYNC1, SYNC2, SYNC3, RST1, RST2: begin
                is_data  = 1'b0;
                is_kcode = 1'b1;
            end
            EOP: begin
                is_data  = 1'b0;
                is_kcode = 1'b1;
                is_eop   = 1'b1;
            end
            default: is_data = 1'b0;
        endcase
    end
endmodule

// File: rtl/pd_rx_ctrl.sv
// pd_rx_ctrl: USB PD receive-path controller behind the BMC decoder.
// Qualifies the preamble, searches for an SOP*/reset ordered set, decodes
// 4b5b symbols into bytes and reports frame completion or abort.
//   clock  in   system clock
//   rst    in   synchronous active-high reset
//   bus    pd_rx_ctrl_if.master: rx_en/bit_rdy/bit_q/pkt_active in;
//          dec_enable, sop_valid/sop_type, byte_valid/byte_data,
//          pkt_done/pkt_err/err_code, busy out (all registered)
module pd_rx_ctrl
    import pd_pkg::*;
#(
    parameter int PREAMBLE_MIN = 32,
    parameter int SOP_TIMEOUT  = 96,
    parameter int MAX_BYTES    = 268
) (
    input  logic         clock,
    input  logic         rst,
    pd_rx_ctrl_if.master bus
);
    state_e      state;
    logic [19:0] sr, sr_nxt;
    logic [5:0]  alt_cnt, alt_nxt;
    logic [7:0]  bit_cnt, bit_cnt_nxt;
    logic [2:0]  sym_cnt;
    logic        nib_odd;
    logic [3:0]  low_nib;
    logic [8:0]  byte_cnt;
    logic        act_q, act_fall;

    logic        dec_enable_r, sop_valid_r, byte_valid_r, pkt_done_r, pkt_err_r, busy_r;
    logic [2:0]  sop_type_r, err_code_r;
    logic [7:0]  byte_data_r;

    logic [3:0]  sym_nib;
    logic        sym_data, sym_eop, sym_kcode, sym_bad;
    logic        os_hit;
    sop_type_e   os_type;

    // Everything is evaluated on the post-shift view so a condition completed
    // by the current bit registers its output on this edge.
    assign sr_nxt      = {bus.bit_q, sr[19:1]};
    assign bit_cnt_nxt = bit_cnt + 8'd1;
    // Previous bit is the newest bit in the shift register.
    assign alt_nxt     = (bus.bit_q == sr[19]) ? 6'd1 :
                         (&alt_cnt)            ? alt_cnt : alt_cnt + 6'd1;
    assign act_fall    = act_q & ~bus.pkt_active;
    assign sym_bad     = sym_kcode | ~sym_data;

    // After five shifts the current symbol sits in sr[19:15], bit0 at sr[15].
    pd_4b5b_dec u_dec (
        .sym      (sr_nxt[19:15]),
        .nibble   (sym_nib),
        .is_data  (sym_data),
        .is_eop   (sym_eop),
        .is_kcode (sym_kcode)
    );

    // Reset ordered sets take priority over SOP variants.
    always_comb begin
        os_hit  = 1'b1;
        os_type = SOPT_SOP;
        if      (os_match(sr_nxt, OS_HARD))  os_type = SOPT_HARD;
        else if (os_match(sr_nxt, OS_CABLE)) os_type = SOPT_CABLE;
        else if (os_match(sr_nxt, OS_SOP))   os_type = SOPT_SOP;
        else if (os_match(sr_nxt, OS_SOP1))  os_type = SOPT_SOP1;
        else if (os_match(sr_nxt, OS_SOP2))  os_type = SOPT_SOP2;
        else                                 os_hit  = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state        <= ST_IDLE;
            sr           <= '0;
            alt_cnt      <= '0;
            bit_cnt      <= '0;
            sym_cnt      <= '0;
            nib_odd      <= 1'b0;
            low_nib      <= '0;
            byte_cnt     <= '0;
            act_q        <= 1'b0;
            dec_enable_r <= 1'b0;
            sop_valid_r  <= 1'b0;
            sop_type_r   <= '0;
            byte_valid_r <= 1'b0;
            byte_data_r  <= '0;
            pkt_done_r   <= 1'b0;
            pkt_err_r    <= 1'b0;
            err_code_r   <= '0;
            busy_r       <= 1'b0;
        end else begin
            sop_valid_r  <= 1'b0;
            byte_valid_r <= 1'b0;
            pkt_done_r   <= 1'b0;
            dec_enable_r <= bus.rx_en;
            act_q        <= bus.pkt_active;
            if (bus.bit_rdy) sr <= sr_nxt;

            if (!bus.rx_en) begin
                // Disarm drops the frame without reporting it.
                state   <= ST_IDLE;
                busy_r  <= 1'b0;
                alt_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        alt_cnt <= '0;
                        if (bus.bit_rdy) begin
                            state  <= ST_PRE;
                            busy_r <= 1'b1;
                        end
                    end

                    ST_PRE: if (bus.bit_rdy) begin
                        alt_cnt <= alt_nxt;
                        if (alt_nxt >= 6'(PREAMBLE_MIN)) begin
                            state   <= ST_SOPSRCH;
                            bit_cnt <= '0;
                        end
                    end

                    ST_SOPSRCH: begin
                        if (act_fall) begin
                            pkt_done_r <= 1'b1;
                            pkt_err_r  <= 1'b1;
                            err_code_r <= ERR_CARRIER;
                            state      <= ST_DONE;
                        end else if (bus.bit_rdy) begin
                            bit_cnt <= bit_cnt_nxt;
                            if (bit_cnt_nxt >= 8'd20 && os_hit) begin
                                sop_valid_r <= 1'b1;
                                sop_type_r  <= os_type;
                                if (os_type == SOPT_HARD || os_type == SOPT_CABLE) begin
                                    pkt_done_r <= 1'b1;
                                    pkt_err_r  <= 1'b0;
                                    err_code_r <= ERR_NONE;
                                    state      <= ST_DONE;
                                end else begin
                                    sym_cnt  <= '0;
                                    nib_odd  <= 1'b0;
                                    byte_cnt <= '0;
                                    state    <= ST_DATA;
                                end
                            end else if (bit_cnt_nxt >= 8'(SOP_TIMEOUT)) begin
                                pkt_done_r <= 1'b1;
                                pkt_err_r  <= 1'b1;
                                err_code_r <= ERR_TIMEOUT;
                                state      <= ST_DONE;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (act_fall) begin
                            pkt_done_r <= 1'b1;
                            pkt_err_r  <= 1'b1;
                            err_code_r <= ERR_CARRIER;
                            state      <= ST_DONE;
                        end else if (bus.bit_rdy) begin
                            if (sym_cnt == 3'd4) begin
                                sym_cnt <= '0;
                                if (sym_eop) begin
                                    // An odd nibble count means a half byte is stranded.
                                    pkt_done_r <= 1'b1;
                                    pkt_err_r  <= nib_odd;
                                    err_code_r <= nib_odd ? ERR_ODD : ERR_NONE;
                                    state      <= ST_DONE;
                                end else if (sym_bad) begin
                                    pkt_done_r <= 1'b1;
                                    pkt_err_r  <= 1'b1;
                                    err_code_r <= ERR_SYM;
                                    state      <= ST_DONE;
                                end else if (!nib_odd) begin
                                    low_nib <= sym_nib;
                                    nib_odd <= 1'b1;
                                end else if (byte_cnt == 9'(MAX_BYTES)) begin
                                    // The byte that would overflow is withheld.
                                    pkt_done_r <= 1'b1;
                                    pkt_err_r  <= 1'b1;
                                    err_code_r <= ERR_OVF;
                                    state      <= ST_DONE;
                                end else begin
                                    byte_valid_r <= 1'b1;
                                    byte_data_r  <= {sym_nib, low_nib};
                                    byte_cnt     <= byte_cnt + 9'd1;
                                    nib_odd      <= 1'b0;
                                end
                            end else begin
                                sym_cnt <= sym_cnt + 3'd1;
                            end
                        end
                    end

                    ST_DONE: if (!bus.pkt_active) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end

                    default: begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.dec_enable = dec_enable_r;
    assign bus.sop_valid  = sop_valid_r;
    assign bus.sop_type   = sop_type_r;
    assign bus.byte_valid = byte_valid_r;
    assign bus.byte_data  = byte_data_r;
    assign bus.pkt_done   = pkt_done_r;
    assign bus.pkt_err    = pkt_err_r;
    assign bus.err_code   = err_code_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_pd_rx_ctrl.sv
// tb_pd_rx_ctrl: directed frames into pd_rx_ctrl with hand-computed expectations.
// A negedge monitor tallies sop/byte/done pulses; each test snapshots the tallies
// and checks the deltas and the last reported values.
module tb_pd_rx_ctrl;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    pd_rx_ctrl_if bus ();

    pd_rx_ctrl #(
        .PREAMBLE_MIN (32),
        .SOP_TIMEOUT  (96),
        .MAX_BYTES    (268)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    localparam logic [4:0] K_S1  = 5'b11000;
    localparam logic [4:0] K_S2  = 5'b10001;
    localparam logic [4:0] K_S3  = 5'b00110;
    localparam logic [4:0] K_R1  = 5'b00111;
    localparam logic [4:0] K_R2  = 5'b11001;
    localparam logic [4:0] K_EOP = 5'b01101;

    logic [4:0] d5b [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                             5'b01010, 5'b01011, 5'b01110, 5'b01111,
                             5'b10010, 5'b10011, 5'b10110, 5'b10111,
                             5'b11010, 5'b11011, 5'b11100, 5'b11101};

    logic [19:0] outs;
    assign outs = {bus.dec_enable, bus.sop_valid, bus.sop_type, bus.byte_valid,
                   bus.byte_data, bus.pkt_done, bus.pkt_err, bus.err_code, bus.busy};

    // pulse monitor
    int         n_sop, n_done, n_same;
    logic [2:0] last_type = 3'd7;
    logic [3:0] last_res  = 4'hF;   // {pkt_err, err_code}
    logic [7:0] bytes_q [$];

    always @(negedge clock) begin
        if (bus.sop_valid) begin
            n_sop     <= n_sop + 1;
            last_type <= bus.sop_type;
        end
        if (bus.byte_valid) bytes_q.push_back(bus.byte_data);
        if (bus.pkt_done) begin
            n_done   <= n_done + 1;
            last_res <= {bus.pkt_err, bus.err_code};
        end
        if (bus.sop_valid && bus.pkt_done) n_same <= n_same + 1;
    end

    int n_vec, n_bad;
    int s_sop, s_byte, s_done, s_same;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_sop  = n_sop;
        s_byte = bytes_q.size();
        s_done = n_done;
        s_same = n_same;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clock);
        bus.bit_rdy = 1'b1;
        bus.bit_q   = b;
        @(negedge clock);
        bus.bit_rdy = 1'b0;
    endtask

    task automatic send_sym(input logic [4:0] s);
        for (int i = 0; i < 5; i++) send_bit(s[i]);
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) send_bit(i[0]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_sym(d5b[b[3:0]]);
        send_sym(d5b[b[7:4]]);
    endtask

    task automatic send_os(input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [4:0] d);
        send_sym(a); send_sym(b); send_sym(c); send_sym(d);
    endtask

    task automatic start_frame();
        @(negedge clock);
        bus.pkt_active = 1'b1;
        snap();
        send_pre(64);
    endtask

    // lets the monitor catch up with the last registered pulse
    task automatic settle();
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic close(input string tag);
        bus.pkt_active = 1'b0;
        repeat (3) @(negedge clock);
        chk(tag, bus.busy, 0);
    endtask

    initial begin
        bus.rx_en      = 1'b0;
        bus.bit_rdy    = 1'b0;
        bus.bit_q      = 1'b0;
        bus.pkt_active = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_outs", outs, 0);
        chk("rst_busy", bus.busy, 0);
        rst       = 1'b0;
        bus.rx_en = 1'b1;
        @(negedge clock);
        chk("dec_en", bus.dec_enable, 1);

        // SOP + A1, 3C + EOP
        start_frame();
        send_os(K_S1, K_S1, K_S1, K_S2);
        send_byte(8'hA1);
        send_byte(8'h3C);
        send_sym(K_EOP);
        settle();
        chk("t1_nsop",  n_sop - s_sop, 1);
        chk("t1_type",  last_type, 0);
        chk("t1_nbyte", bytes_q.size() - s_byte, 2);
        chk("t1_b0",    bytes_q[s_byte], 8'hA1);
        chk("t1_b1",    bytes_q[s_byte+1], 8'h3C);
        chk("t1_ndone", n_done - s_done, 1);
        chk("t1_res",   last_res, 4'h0);
        chk("t1_busy",  bus.busy, 1);
        close("t1_idle");

        // SOP' with one corrupted field, empty payload
        start_frame();
        send_os(K_S1, 5'b00000, K_S3, K_S3);
        send_sym(K_EOP);
        settle();
        chk("t2_nsop", n_sop - s_sop, 1);
        chk("t2_type", last_type, 1);
        chk("t2_res",  last_res, 4'h0);
        close("t2_idle");

        // Hard Reset: sop_valid and pkt_done together
        start_frame();
        send_os(K_R1, K_R1, K_R1, K_R2);
        settle();
        chk("t3_type",  last_type, 3);
        chk("t3_same",  n_same - s_same, 1);
        chk("t3_res",   last_res, 4'h0);
        chk("t3_nbyte", bytes_q.size() - s_byte, 0);
        close("t3_idle");

        // invalid symbol
        start_frame();
        send_os(K_S1, K_S1, K_S1, K_S2);
        send_sym(5'b00000);
        settle();
        chk("t4a_res", last_res, 4'h9);
        close("t4a_idle");

        // 3 nibbles + EOP
        start_frame();
        send_os(K_S1, K_S1, K_S1, K_S2);
        send_byte(8'h5A);
        send_sym(d5b[7]);
        send_sym(K_EOP);
        settle();
        chk("t4b_nbyte", bytes_q.size() - s_byte, 1);
        chk("t4b_b0",    bytes_q[s_byte], 8'h5A);
        chk("t4b_res",   last_res, 4'hC);
        close("t4b_idle");

        // endless preamble -> SOP timeout
        start_frame();
        send_pre(80);
        settle();
        chk("t5a_nsop",  n_sop - s_sop, 0);
        chk("t5a_ndone", n_done - s_done, 1);
        chk("t5a_res",   last_res, 4'hA);
        close("t5a_idle");

        // 269 bytes -> 268 emitted, then overflow
        start_frame();
        send_os(K_S1, K_S1, K_S1, K_S2);
        for (int i = 0; i < 269; i++) send_byte(i[7:0]);
        settle();
        chk("t5b_nbyte", bytes_q.size() - s_byte, 268);
        chk("t5b_first", bytes_q[s_byte], 8'h00);
        chk("t5b_last",  bytes_q[s_byte+267], 8'h0B);
        chk("t5b_res",   last_res, 4'hB);
        close("t5b_idle");

        // carrier lost mid-DATA
        start_frame();
        send_os(K_S1, K_S1, K_S1, K_S2);
        send_byte(8'h11);
        send_sym(d5b[2]);
        @(negedge clock);
        bus.pkt_active = 1'b0;
        settle();
        chk("t6a_ndone", n_done - s_done, 1);
        chk("t6a_res",   last_res, 4'hD);
        close("t6a_idle");

        // reset mid-DATA: silent abort
        start_frame();
        send_os(K_S1, K_S1, K_S1, K_S2);
        send_byte(8'h22);
        rst = 1'b1;
        @(negedge clock);
        chk("t6b_outs", outs, 0);
        rst            = 1'b0;
        bus.pkt_active = 1'b0;
        settle();
        chk("t6b_ndone", n_done - s_done, 0);

        // rx_en dropped mid-DATA: silent abort
        start_frame();
        send_os(K_S1, K_S1, K_S1, K_S2);
        send_byte(8'h33);
        bus.rx_en = 1'b0;
        repeat (2) @(negedge clock);
        chk("t7_busy",  bus.busy, 0);
        chk("t7_dec",   bus.dec_enable, 0);
        settle();
        chk("t7_ndone", n_done - s_done, 0);
        bus.rx_en      = 1'b1;
        bus.pkt_active = 1'b0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
